// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and memory-stage requests onto one backing memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last (default: dmem wins).
module mem_port_arbiter #(
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    input  logic        imem_kill,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        arb_timeout
);
    localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(WATCHDOG_CYCLES);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t         state;
    logic           kill_pending;
    logic [WDW-1:0] wd_cnt;
    logic           i_req, d_req, done;
    logic           grant_i, grant_d;

    // A killed fetch is not eligible for a grant in the same cycle.
    assign i_req = (|imem_rmask) & ~imem_kill;
    assign d_req = (|dmem_rmask) | (|dmem_wmask);
    assign done  = (state != IDLE) & mem_resp;

    assign imem_resp  = (state == SERVE_I) & mem_resp & ~kill_pending & ~imem_kill;
    assign dmem_resp  = (state == SERVE_D) & mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_d <= 1'b0;
        else if (grant_i | grant_d)
            last_d <= grant_d;
    end
`endif

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    grant_i = last_d;
                    grant_d = ~last_d;
`else
                    grant_d = 1'b1;
`endif
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end
            end
            // Back-to-back hand-off only to the requester that was waiting.
            SERVE_I: grant_d = mem_resp & d_req;
            SERVE_D: grant_i = mem_resp & i_req;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mem_addr     <= '0;
            mem_rmask    <= '0;
            mem_wmask    <= '0;
            mem_wdata    <= '0;
            kill_pending <= 1'b0;
            wd_cnt       <= '0;
            arb_timeout  <= 1'b0;
        end else if (grant_d) begin
            state        <= SERVE_D;
            mem_addr     <= dmem_addr;
            mem_rmask    <= dmem_rmask;
            mem_wmask    <= dmem_wmask;
            mem_wdata    <= dmem_wdata;
            kill_pending <= 1'b0;
            wd_cnt       <= '0;
        end else if (grant_i) begin
            state        <= SERVE_I;
            mem_addr     <= imem_addr;
            mem_rmask    <= imem_rmask;
            mem_wmask    <= '0;
            mem_wdata    <= '0;
            kill_pending <= 1'b0;
            wd_cnt       <= '0;
        end else if (done) begin
            state        <= IDLE;
            mem_rmask    <= '0;
            mem_wmask    <= '0;
            kill_pending <= 1'b0;
        end else if (state != IDLE) begin
            if (wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + WDW'(1);
            if (wd_cnt + WDW'(1) == WD_MAX)
                arb_timeout <= 1'b1;
            if (state == SERVE_I && imem_kill)
                kill_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int WD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
    logic        imem_kill, imem_resp, dmem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        mem_resp, arb_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WATCHDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_kill(imem_kill),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .arb_timeout(arb_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record plus sticky flags.
    bit          m_busy, m_own_d, m_killed, m_last_d, m_to, m_new;
    int          m_wait;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_rmask, m_wmask;
    logic        got_i, got_d;
    logic [31:0] got_drdata;

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_killed = 0; m_last_d = 0; m_to = 0; m_new = 0;
        m_wait = 0; m_addr = '0; m_wdata = '0; m_rmask = '0; m_wmask = '0;
    endtask

    task automatic model_step();
        bit i_req, d_req, fin, gi, gd;
        i_req = (imem_rmask != 0) && !imem_kill;
        d_req = (dmem_rmask != 0) || (dmem_wmask != 0);
        fin   = m_busy && mem_resp;
        gi = 0; gd = 0; m_new = 0;
        if (m_busy && !mem_resp) begin
            if (m_wait < WD) m_wait++;
            if (m_wait >= WD) m_to = 1;
            if (!m_own_d && imem_kill) m_killed = 1;
        end
        if (!m_busy) begin
            if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                gd = !m_last_d; gi = m_last_d;
`else
                gd = 1;
`endif
            end else begin
                gi = i_req; gd = d_req;
            end
        end else if (fin) begin
            if (m_own_d) gi = i_req; else gd = d_req;
        end
        if (gi || gd) begin
            m_busy = 1; m_own_d = gd; m_killed = 0; m_wait = 0; m_last_d = gd; m_new = 1;
            if (gd) begin
                m_addr = dmem_addr; m_rmask = dmem_rmask; m_wmask = dmem_wmask; m_wdata = dmem_wdata;
            end else begin
                m_addr = imem_addr; m_rmask = imem_rmask; m_wmask = '0; m_wdata = '0;
            end
        end else if (fin) begin
            m_busy = 0; m_rmask = '0; m_wmask = '0; m_killed = 0;
        end
    endtask

    // Entered at a negedge with inputs driven; returns at the next negedge.
    task automatic cycle();
        bit e_i, e_d;
        #1;
        e_i = m_busy && !m_own_d && mem_resp && !m_killed && !imem_kill;
        e_d = m_busy && m_own_d && mem_resp;
        chk("imem_resp", imem_resp, e_i);
        chk("imem_rdata", imem_rdata, e_i ? mem_rdata : 32'h0);
        chk("dmem_resp", dmem_resp, e_d);
        chk("dmem_rdata", dmem_rdata, e_d ? mem_rdata : 32'h0);
        got_i = imem_resp; got_d = dmem_resp; got_drdata = dmem_rdata;
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_rmask", mem_rmask, m_rmask);
        chk("mem_wmask", mem_wmask, m_wmask);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("arb_timeout", arb_timeout, m_to);
    endtask

    task automatic clear_inputs();
        imem_addr = '0; imem_rmask = '0; imem_kill = 0;
        dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        model_reset();
        got_i = 0; got_d = 0;
        @(negedge clk);
        rst = 1;
        chk("rst_mem_rmask", mem_rmask, 4'h0);
        chk("rst_timeout", arb_timeout, 1'b0);
    endtask

    logic        i_act, d_act, kill_last;
    logic [31:0] i_a, d_a, d_wd;
    logic [3:0]  d_rm, d_wm;
    int          lat_cnt, lat_tgt;
    logic [31:0] ia, da;
    bit          exp_d;

    initial begin
        rst = 0;
        clear_inputs();
        model_reset();
        #3;
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_masks", {mem_rmask, mem_wmask}, 8'h0);
        chk("rst_resp", {imem_resp, dmem_resp, arb_timeout}, 3'b000);
        @(negedge clk);
        rst = 1;

        // Single load, memory answers in the 4th serving cycle
        dmem_rmask = 4'hF; dmem_addr = 32'h100;
        cycle();
        chk("ld_rmask", mem_rmask, 4'hF);
        cycle(); cycle(); cycle();
        mem_resp = 1; mem_rdata = 32'hDEADBEEF;
        cycle();
        chk("ld_resp", got_d, 1'b1);
        chk("ld_data", got_drdata, 32'hDEADBEEF);
        clear_inputs();
        cycle();

        // Simultaneous fetch and store, then D-only, then simultaneous again
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            imem_rmask = 4'hF; imem_addr = 32'h40;
            dmem_wmask = 4'h3; dmem_addr = 32'h200; dmem_wdata = 32'h0000CAFE;
            cycle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("tie_first", mem_addr, pass == 0 ? 32'h200 : 32'h40);
`else
            chk("tie_first", mem_addr, 32'h200);
`endif
            mem_resp = 1; mem_rdata = 32'h5;
            cycle();
            if (got_d) begin dmem_wmask = '0; end
            if (got_i) begin imem_rmask = '0; end
            chk("tie_b2b_mask", {mem_rmask, mem_wmask} != 8'h0, 1'b1);
            cycle();
            clear_inputs();
            cycle();
            if (pass == 0) begin
                dmem_rmask = 4'hF; dmem_addr = 32'h204;
                cycle();
                mem_resp = 1;
                cycle();
                clear_inputs();
            end
        end

        // Kill of a granted fetch, then a dmem request is granted the next cycle
        do_reset();
        imem_rmask = 4'hF; imem_addr = 32'h80;
        cycle();
        imem_kill = 1;
        cycle();
        imem_kill = 0; imem_rmask = '0;
        cycle();
        mem_resp = 1; mem_rdata = 32'h77;
        cycle();
        chk("kill_resp", got_i, 1'b0);
        mem_resp = 0; dmem_rmask = 4'hF; dmem_addr = 32'h300;
        cycle();
        chk("kill_next_d", mem_addr, 32'h300);
        mem_resp = 1;
        cycle();
        clear_inputs();
        // Kill in the same cycle as the response
        imem_rmask = 4'hF; imem_addr = 32'h84;
        cycle();
        imem_kill = 1; mem_resp = 1; mem_rdata = 32'h99;
        cycle();
        chk("kill_same_resp", got_i, 1'b0);
        clear_inputs();
        cycle();

        // Both re-request continuously: grants alternate
        do_reset();
        ia = 32'h1000; da = 32'h2000; exp_d = 1;
        imem_rmask = 4'hF; imem_addr = ia; dmem_rmask = 4'hF; dmem_addr = da;
        cycle();
        for (int k = 0; k < 20; k++) begin
            chk("alt_owner", {30'h0, mem_addr[13:12]}, exp_d ? 32'h2 : 32'h1);
            exp_d = !exp_d;
            mem_resp = 1; mem_rdata = 32'(k);
            cycle();
            if (got_d) da = da + 4;
            if (got_i) ia = ia + 4;
            imem_addr = ia; dmem_addr = da;
        end
        clear_inputs();
        mem_resp = 1;
        cycle();
        mem_resp = 0;
        cycle();

        // Randomized traffic
        do_reset();
        i_act = 0; d_act = 0; kill_last = 0; lat_cnt = 0; lat_tgt = 0;
        i_a = '0; d_a = '0; d_wd = '0; d_rm = '0; d_wm = '0;
        for (int t = 0; t < 3000; t++) begin
            if (got_d) d_act = 0;
            if (got_i || kill_last) i_act = 0;
            if (!d_act && $urandom_range(2) == 0) begin
                d_act = 1;
                d_a = 32'($urandom_range(255)) << 2;
                d_wd = $urandom;
                if ($urandom_range(1) == 1) begin d_rm = 4'hF; d_wm = 4'h0; end
                else begin d_rm = 4'h0; d_wm = 4'($urandom_range(15, 1)); end
            end
            if (!i_act && $urandom_range(2) == 0) begin
                i_act = 1;
                i_a = 32'($urandom_range(255)) << 2;
            end
            imem_kill = i_act && ($urandom_range(11) == 0);
            kill_last = imem_kill;
            imem_addr = i_a; imem_rmask = i_act ? 4'hF : 4'h0;
            dmem_addr = d_a; dmem_wdata = d_wd;
            dmem_rmask = d_act ? d_rm : 4'h0; dmem_wmask = d_act ? d_wm : 4'h0;
            if (m_busy) begin
                if (lat_cnt >= lat_tgt) mem_resp = 1;
                else begin mem_resp = 0; lat_cnt++; end
            end else begin
                mem_resp = ($urandom_range(15) == 0);
            end
            mem_rdata = $urandom;
            cycle();
            if (m_new) begin lat_cnt = 0; lat_tgt = $urandom_range(4); end
        end

        // Watchdog
        do_reset();
        dmem_rmask = 4'hF; dmem_addr = 32'h500;
        cycle();
        for (int w = 1; w <= 10; w++) begin
            cycle();
            chk("wd_flag", arb_timeout, w >= WD);
        end
        mem_resp = 1; mem_rdata = 32'h1234;
        cycle();
        chk("wd_resp", got_d, 1'b1);
        chk("wd_data", got_drdata, 32'h1234);
        clear_inputs();
        cycle();
        chk("wd_sticky", arb_timeout, 1'b1);

        // Async reset in the middle of a store
        do_reset();
        dmem_wmask = 4'hF; dmem_addr = 32'h600; dmem_wdata = 32'hA5A5A5A5;
        cycle();
        cycle();
        #2 rst = 0;
        #1;
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_wmask", mem_wmask, 4'h0);
        chk("arst_wdata", mem_wdata, 32'h0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1;
        mem_resp = 1; mem_rdata = 32'hBAD;
        cycle();
        chk("stray_dresp", got_d, 1'b0);
        chk("stray_iresp", got_i, 1'b0);
        mem_resp = 0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
